d8_writeback: RTL and testbench
===============================

D8_WRITEBACK -- requirements
Module: d8_writeback

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: sys_clk is the clock and sys_rst is the reset.
REQ-002 Parameter NREG, default 8, meaning number of 8-bit general registers; address width SHALL be 3 bits.
REQ-003 sys_clk  in  1  rising-edge clock for all state.
REQ-004 sys_rst  in  1  synchronous active-high reset.
REQ-005 ra_addr  in  3  read address feeding ALU operand a.
REQ-006 rb_addr  in  3  read address feeding ALU operand b.
REQ-007 a  out  8  operand a to ALU.
REQ-008 b  out  8  operand b to ALU.
REQ-009 wb_valid  in  1  writeback request valid.
REQ-010 wb_ready  out  1  stage can accept request this cycle.
REQ-011 wb_addr  in  3  destination register.
REQ-012 wb_we  in  1  write s into the destination register.
REQ-013 wb_fwe  in  1  write n,o,z,c into the status register.
REQ-014 s  in  8  ALU result.
REQ-015 n, o, z, c  in  1 each  ALU flags.
REQ-016 hold  in  1  downstream stall; blocks commit.
REQ-017 flags  out  4  committed status {n,o,z,c}, bit3 = n, bit0 = c.

Function
REQ-018 Stage register P SHALL hold {valid, addr, data, flags, we, fwe}; accept occurs when wb_valid && wb_ready, capturing inputs at that edge.
REQ-019 wb_ready SHALL equal !P.valid || !hold (combinational).
REQ-020 Commit SHALL occur when P.valid && !hold: if P.we, write P.data to reg[P.addr]; if P.fwe, write P.flags to the status register.
REQ-021 Same-cycle commit and accept SHALL both take effect: the old P commits, new P is loaded, P.valid stays 1.
REQ-022 Commit without accept SHALL clear P.valid; hold with P.valid SHALL keep P unchanged and deassert wb_ready.
REQ-023 Latency: accept at edge k SHALL make data visible in the array/flags after edge k+1 when hold = 0.
REQ-024 Read ports a, b SHALL be combinational; if P.valid && P.we && P.addr == read address, the port SHALL return P.data (bypass), else the array value.
REQ-025 Both ports reading the same address SHALL return identical values, including bypass.
REQ-026 flags SHALL show only committed status; no bypass on flags.
REQ-027 wb_valid with wb_we = wb_fwe = 0 SHALL still be accepted and committed as a no-op with no state change.
REQ-028 Inputs sampled only at accept; s/flags changes while not accepting SHALL have no effect.
REQ-029 wb_valid while wb_ready = 0 SHALL be ignored; the requester holds it stable.

Reset
REQ-030 On sys_rst at an edge: P.valid = 0, all registers = 8'h00, status = 4'b0000; pending P SHALL be discarded, not committed.
REQ-031 After reset: a = b = 8'h00, flags = 4'b0000, wb_ready = 1.
REQ-032 Reset SHALL take priority over accept and commit in the same cycle.

Structure
REQ-033 Shared include d8_defines.vh SHALL hold NREG, the register-address width, and the flag bit positions (N=3, O=2, Z=1, C=0).
REQ-034 Sub-module d8_regfile SHALL implement the NREG x 8 array: 2 asynchronous read ports, 1 synchronous write port, synchronous reset clear.
REQ-035 Stage register, handshake, bypass mux and status register SHALL reside in d8_writeback.

Verification
REQ-036 Reset, then ra_addr=0, rb_addr=7 -> a=8'h00, b=8'h00, flags=0, wb_ready=1.
REQ-037 Accept addr=3, s=8'h5A, we=1, fwe=0, hold=0; ra_addr=3 -> a=8'h5A in the cycle after accept (bypass), and still 8'h5A after commit.
REQ-038 Accept s=8'h00, z=1, c=1, fwe=1, we=0 -> flags=4'b0011 one edge after commit; no register changes.
REQ-039 P valid with hold=1 for 3 cycles -> wb_ready=0, the offered request is ignored, array unchanged; hold released -> commit on the next edge.
REQ-040 Back-to-back accepts to addr 2 (8'h11, then 8'h22), hold=0 -> reg2 ends 8'h22, and rb_addr=2 reads 8'h11 then 8'h22.
REQ-041 Accept addr=5, s=8'hFF, then sys_rst before commit -> reg5=8'h00, P.valid=0.

Source files
------------

// File: rtl/d8_writeback_pkg.sv
// Shared constants and types for the d8 writeback stage: register-file geometry,
// status flag bit positions and the stage-register layout.
package d8_writeback_pkg;

  localparam int NREG   = 8;
  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int FW     = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_O = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [FW-1:0] flags;
    logic          we;
    logic          fwe;
  } stage_t;

  // A pending register write shadows the array for reads of the same address.
  function automatic logic bypass_hit(input stage_t p, input logic [AW-1:0] raddr);
    return p.valid && p.we && (p.addr == raddr);
  endfunction

endpackage

// File: rtl/d8_writeback_regfile.sv
// NREG x 8 general register array: two asynchronous read ports, one synchronous
// write port, synchronous clear on reset.
module d8_regfile
  import d8_writeback_pkg::*;
#(
  parameter int NREG = d8_writeback_pkg::NREG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  logic [DW-1:0] mem_r [NREG];

  // Array storage: reset clears every entry, otherwise one write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Asynchronous read ports.
  always_comb begin
    rdata0 = mem_r[raddr0];
    rdata1 = mem_r[raddr1];
  end

endmodule

// File: rtl/d8_writeback.sv
// Writeback stage: one-entry stage register with valid/ready handshake, commit to
// the register array and status register, and read-port bypass of the pending write.
module d8_writeback
  import d8_writeback_pkg::*;
#(
  parameter int NREG = d8_writeback_pkg::NREG
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [AW-1:0] wb_addr,
  input  logic          wb_we,
  input  logic          wb_fwe,
  input  logic [DW-1:0] s,
  input  logic          n,
  input  logic          o,
  input  logic          z,
  input  logic          c,
  input  logic          hold,
  output logic [FW-1:0] flags
);

  stage_t        stage_r;
  stage_t        stage_nxt_s;
  logic [FW-1:0] status_r;
  logic          accept_s;
  logic          commit_s;
  logic [DW-1:0] arr_a_s;
  logic [DW-1:0] arr_b_s;

  // Handshake: the stage frees up whenever its content is leaving this cycle.
  always_comb begin
    wb_ready = !stage_r.valid || !hold;
    accept_s = wb_valid && wb_ready;
    commit_s = stage_r.valid && !hold;
  end

  // Next stage contents: a new request overrides, a lone commit empties the stage.
  always_comb begin
    stage_nxt_s = stage_r;
    if (accept_s) begin
      stage_nxt_s.valid          = 1'b1;
      stage_nxt_s.addr           = wb_addr;
      stage_nxt_s.data           = s;
      stage_nxt_s.flags[FLAG_N]  = n;
      stage_nxt_s.flags[FLAG_O]  = o;
      stage_nxt_s.flags[FLAG_Z]  = z;
      stage_nxt_s.flags[FLAG_C]  = c;
      stage_nxt_s.we             = wb_we;
      stage_nxt_s.fwe            = wb_fwe;
    end else if (commit_s) begin
      stage_nxt_s.valid = 1'b0;
    end else begin
      stage_nxt_s = stage_r;
    end
  end

  // Stage register; reset discards any pending entry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stage_r <= '0;
    end else begin
      stage_r <= stage_nxt_s;
    end
  end

  // Committed status register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      status_r <= 4'b0000;
    end else if (commit_s && stage_r.fwe) begin
      status_r <= stage_r.flags;
    end else begin
      status_r <= status_r;
    end
  end

  d8_regfile #(.NREG(NREG)) u_regfile (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .we     (commit_s && stage_r.we),
    .waddr  (stage_r.addr),
    .wdata  (stage_r.data),
    .raddr0 (ra_addr),
    .raddr1 (rb_addr),
    .rdata0 (arr_a_s),
    .rdata1 (arr_b_s)
  );

  // Operand ports with bypass; flags expose committed state only.
  always_comb begin
    a     = bypass_hit(stage_r, ra_addr) ? stage_r.data : arr_a_s;
    b     = bypass_hit(stage_r, rb_addr) ? stage_r.data : arr_b_s;
    flags = status_r;
  end

endmodule

// File: tb/tb_d8_writeback.sv
// Randomized scoreboard bench for d8_writeback against a queue-based reference model.
module tb_d8_writeback;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] ra_addr, rb_addr, wb_addr;
  logic [7:0] a, b, s;
  logic       wb_valid, wb_ready, wb_we, wb_fwe, hold;
  logic       n, o, z, c;
  logic [3:0] flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] flags;
    logic       ready;
  } exp_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic [3:0] flags;
    logic       we;
    logic       fwe;
  } txn_t;

  exp_t       exp_q[$];
  txn_t       pend_q[$];
  logic [7:0] regs [8];
  logic [3:0] status;
  bit         known = 1'b0;

  d8_writeback dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .a(a), .b(b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_we(wb_we), .wb_fwe(wb_fwe), .s(s),
    .n(n), .o(o), .z(z), .c(c), .hold(hold), .flags(flags)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("a", a, e.a);
      chk("b", b, e.b);
      chk("flags", {4'h0, flags}, {4'h0, e.flags});
      chk("wb_ready", {7'h00, wb_ready}, {7'h00, e.ready});
    end
  end

  function automatic logic [7:0] model_read(input logic [2:0] ra);
    if (pend_q.size() > 0 && pend_q[0].we && pend_q[0].addr == ra) return pend_q[0].data;
    return regs[ra];
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance the model.
  task automatic step(input logic rst_i, input logic v_i, input logic [2:0] ad_i,
                      input logic we_i, input logic fwe_i, input logic [7:0] s_i,
                      input logic [3:0] f_i, input logic hold_i,
                      input logic [2:0] ra_i, input logic [2:0] rb_i);
    exp_t e;
    txn_t t;
    bit   rdy, com;
    sys_rst = rst_i; wb_valid = v_i; wb_addr = ad_i; wb_we = we_i; wb_fwe = fwe_i;
    s = s_i; {n, o, z, c} = f_i; hold = hold_i; ra_addr = ra_i; rb_addr = rb_i;
    rdy = (pend_q.size() == 0) || !hold_i;
    if (known) begin
      e.a = model_read(ra_i); e.b = model_read(rb_i); e.flags = status; e.ready = rdy;
      exp_q.push_back(e);
    end
    if (rst_i) begin
      foreach (regs[i]) regs[i] = 8'h00;
      status = 4'b0000;
      pend_q.delete();
      known = 1'b1;
    end else begin
      com = (pend_q.size() > 0) && !hold_i;
      if (com) begin
        t = pend_q.pop_front();
        if (t.we)  regs[t.addr] = t.data;
        if (t.fwe) status = t.flags;
      end
      if (v_i && rdy) begin
        t.addr = ad_i; t.data = s_i; t.flags = f_i; t.we = we_i; t.fwe = fwe_i;
        pend_q.push_back(t);
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input logic [2:0] ra_i, input logic [2:0] rb_i);
    step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, ra_i, rb_i);
  endtask

  initial begin
    logic       rv, rwe, rfwe, rhold, rrst;
    logic [2:0] rad, rra, rrb;
    logic [7:0] rs;
    logic [3:0] rf;
    bit         blocked;
    @(posedge sys_clk); #1;
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 3'd7);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd0, 3'd7);
    idle(3'd0, 3'd7);
    // Single write with bypass then committed read.
    step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 8'h5A, 4'h0, 1'b0, 3'd3, 3'd0);
    idle(3'd3, 3'd3);
    idle(3'd3, 3'd3);
    // Flags-only write.
    step(1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 8'h00, 4'b0011, 1'b0, 3'd1, 3'd3);
    idle(3'd1, 3'd3);
    idle(3'd1, 3'd3);
    // Stall: pending entry held, second request refused until hold drops.
    step(1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h33, 4'h0, 1'b0, 3'd4, 3'd6);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'h77, 4'hF, 1'b1, 3'd4, 3'd6);
    step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 8'h77, 4'hF, 1'b0, 3'd4, 3'd6);
    idle(3'd4, 3'd6);
    idle(3'd4, 3'd6);
    // Back-to-back writes to the same register.
    step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h11, 4'h0, 1'b0, 3'd0, 3'd2);
    step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h22, 4'h0, 1'b0, 3'd0, 3'd2);
    idle(3'd0, 3'd2);
    idle(3'd0, 3'd2);
    // Reset discards a pending write.
    step(1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'hFF, 4'hF, 1'b0, 3'd5, 3'd2);
    step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 3'd5, 3'd2);
    idle(3'd5, 3'd2);
    idle(3'd5, 3'd6);
    // Random traffic; a refused request is held stable until accepted.
    blocked = 1'b0;
    rv = 1'b0; rad = 3'd0; rwe = 1'b0; rfwe = 1'b0; rs = 8'h00; rf = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if (!blocked) begin
        rv = ($urandom_range(0, 9) < 6); rad = 3'($urandom_range(0, 7));
        rwe = 1'($urandom_range(0, 1)); rfwe = 1'($urandom_range(0, 1));
        rs = 8'($urandom_range(0, 255)); rf = 4'($urandom_range(0, 15));
      end
      rhold = ($urandom_range(0, 9) < 3);
      rrst  = ($urandom_range(0, 99) == 0);
      rra = 3'($urandom_range(0, 7)); rrb = 3'($urandom_range(0, 7));
      blocked = rv && !rrst && (pend_q.size() > 0) && rhold;
      step(rrst, rv, rad, rwe, rfwe, rs, rf, rhold, rra, rrb);
    end
    for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge sys_clk);
    chk("drain", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
